// File: rtl/gpu_timing_pkg.sv
// Shared register map, configuration struct and helpers for the programmable
// video timing generator and its per-axis sub-block.
package gpu_timing_pkg;

    localparam int CNT_W = 12;
    localparam int SUM_W = 14;
    localparam logic [SUM_W-1:0] MAX_TOTAL = 14'd4096;

    localparam logic [3:0] ADDR_H_RES  = 4'd0;
    localparam logic [3:0] ADDR_H_FP   = 4'd1;
    localparam logic [3:0] ADDR_H_SYNC = 4'd2;
    localparam logic [3:0] ADDR_H_BP   = 4'd3;
    localparam logic [3:0] ADDR_V_RES  = 4'd4;
    localparam logic [3:0] ADDR_V_FP   = 4'd5;
    localparam logic [3:0] ADDR_V_SYNC = 4'd6;
    localparam logic [3:0] ADDR_V_BP   = 4'd7;
    localparam logic [3:0] ADDR_POL    = 4'd8;
    localparam logic [3:0] ADDR_LINE   = 4'd9;
    localparam logic [3:0] ADDR_SCALE  = 4'd10;

    typedef struct packed {
        logic [CNT_W-1:0] hRes;
        logic [CNT_W-1:0] hFp;
        logic [CNT_W-1:0] hSync;
        logic [CNT_W-1:0] hBp;
        logic [CNT_W-1:0] vRes;
        logic [CNT_W-1:0] vFp;
        logic [CNT_W-1:0] vSync;
        logic [CNT_W-1:0] vBp;
        logic [1:0]       pol;
        logic [CNT_W-1:0] lineCompare;
        logic [1:0]       hShift;
        logic [1:0]       vShift;
    } timing_cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } commit_state_t;

    // Widened so that four maximal 12-bit fields can never wrap the sum.
    function automatic logic [SUM_W-1:0] axisTotal(
        input logic [CNT_W-1:0] fp,
        input logic [CNT_W-1:0] sync,
        input logic [CNT_W-1:0] bp,
        input logic [CNT_W-1:0] res
    );
        return SUM_W'(fp) + SUM_W'(sync) + SUM_W'(bp) + SUM_W'(res);
    endfunction

    function automatic timing_cfg_t makeDefaultCfg(
        input int         hRes,
        input int         hFp,
        input int         hSync,
        input int         hBp,
        input int         vRes,
        input int         vFp,
        input int         vSync,
        input int         vBp,
        input logic [1:0] pol
    );
        timing_cfg_t cfg;
        cfg.hRes        = CNT_W'(hRes);
        cfg.hFp         = CNT_W'(hFp);
        cfg.hSync       = CNT_W'(hSync);
        cfg.hBp         = CNT_W'(hBp);
        cfg.vRes        = CNT_W'(vRes);
        cfg.vFp         = CNT_W'(vFp);
        cfg.vSync       = CNT_W'(vSync);
        cfg.vBp         = CNT_W'(vBp);
        cfg.pol         = pol;
        cfg.lineCompare = '0;
        cfg.hShift      = '0;
        cfg.vShift      = '0;
        return cfg;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: decodes a position counter into sync, active flag,
// end-of-axis flag and the down-scaled active coordinate.
module timing_axis
    import gpu_timing_pkg::*;
(
    input  logic [CNT_W-1:0] i_count,
    input  logic [CNT_W-1:0] i_fp,
    input  logic [CNT_W-1:0] i_sync,
    input  logic [CNT_W-1:0] i_bp,
    input  logic [CNT_W-1:0] i_res,
    input  logic             i_pol,
    input  logic [1:0]       i_shift,
    output logic             o_sync,
    output logic             o_active,
    output logic             o_last,
    output logic [CNT_W-1:0] o_coord
);

    logic [SUM_W-1:0] w_count;
    logic [SUM_W-1:0] w_syncEnd;
    logic [SUM_W-1:0] w_activeSta;
    logic [SUM_W-1:0] w_total;
    logic [SUM_W-1:0] w_offset;
    logic             w_inSync;

    assign w_count     = SUM_W'(i_count);
    assign w_syncEnd   = SUM_W'(i_fp) + SUM_W'(i_sync);
    assign w_activeSta = w_syncEnd + SUM_W'(i_bp);
    assign w_total     = axisTotal(i_fp, i_sync, i_bp, i_res);
    assign w_offset    = w_count - w_activeSta;

    // Segment order along the axis is front porch, sync, back porch, active.
    assign w_inSync = (w_count >= SUM_W'(i_fp)) && (w_count < w_syncEnd);
    assign o_sync   = i_pol ? w_inSync : ~w_inSync;
    assign o_active = (w_count >= w_activeSta) && (w_count < w_total);
    assign o_last   = (w_count == (w_total - SUM_W'(1)));
    assign o_coord  = o_active ? CNT_W'(w_offset >> i_shift) : '0;

endmodule

// File: rtl/timing_generator_prog.sv
// Programmable video timing generator: shadow/active configuration with
// frame-boundary commit, raster counters and video control outputs.
module timing_generator_prog
    import gpu_timing_pkg::*;
#(
    parameter int         H_RES_D         = 640,
    parameter int         H_FP_D          = 16,
    parameter int         H_SYNC_D        = 96,
    parameter int         H_BP_D          = 48,
    parameter int         V_RES_D         = 480,
    parameter int         V_FP_D          = 10,
    parameter int         V_SYNC_D        = 2,
    parameter int         V_BP_D          = 33,
    parameter logic [1:0] POL_D           = 2'b00,
    parameter int         INTERRUPT_TICKS = 32
)(
    input  logic             clkPixel,
    input  logic             nReset,
    input  logic             cfgWe,
    input  logic [3:0]       cfgAddr,
    input  logic [11:0]      cfgData,
    input  logic             cfgApply,
    output logic             cfgBusy,
    output logic             cfgErr,
    output logic [11:0]      h_count,
    output logic [11:0]      v_count,
    output logic [11:0]      x,
    output logic [11:0]      y,
    output logic             hsync,
    output logic             vsync,
    output logic             csync,
    output logic             blank,
    output logic             frameDrawn,
    output logic             lineIrq
);

    localparam timing_cfg_t CFG_DEFAULT = makeDefaultCfg(H_RES_D, H_FP_D, H_SYNC_D, H_BP_D,
                                                         V_RES_D, V_FP_D, V_SYNC_D, V_BP_D,
                                                         POL_D);

    timing_cfg_t      r_shadow;
    timing_cfg_t      r_active;
    commit_state_t    r_state;
    commit_state_t    w_stateNext;
    logic [CNT_W-1:0] r_hCount;
    logic [CNT_W-1:0] r_vCount;
    logic             r_cfgErr;

    logic [SUM_W-1:0] w_shHTotal;
    logic [SUM_W-1:0] w_shVTotal;
    logic             w_shadowOk;
    logic             w_hLast;
    logic             w_vLast;
    logic             w_wrap;
    logic             w_commit;
    logic             w_writeReject;
    logic             w_hActive;
    logic             w_vActive;
    logic             w_hsync;
    logic             w_vsync;
    logic [CNT_W-1:0] w_hCoord;
    logic [CNT_W-1:0] w_vCoord;

    timing_axis u_hAxis (
        .i_count  (r_hCount),
        .i_fp     (r_active.hFp),
        .i_sync   (r_active.hSync),
        .i_bp     (r_active.hBp),
        .i_res    (r_active.hRes),
        .i_pol    (r_active.pol[0]),
        .i_shift  (r_active.hShift),
        .o_sync   (w_hsync),
        .o_active (w_hActive),
        .o_last   (w_hLast),
        .o_coord  (w_hCoord)
    );

    timing_axis u_vAxis (
        .i_count  (r_vCount),
        .i_fp     (r_active.vFp),
        .i_sync   (r_active.vSync),
        .i_bp     (r_active.vBp),
        .i_res    (r_active.vRes),
        .i_pol    (r_active.pol[1]),
        .i_shift  (r_active.vShift),
        .o_sync   (w_vsync),
        .o_active (w_vActive),
        .o_last   (w_vLast),
        .o_coord  (w_vCoord)
    );

    // A commit is only accepted when both shadow totals fit the 12-bit counters.
    assign w_shHTotal = axisTotal(r_shadow.hFp, r_shadow.hSync, r_shadow.hBp, r_shadow.hRes);
    assign w_shVTotal = axisTotal(r_shadow.vFp, r_shadow.vSync, r_shadow.vBp, r_shadow.vRes);
    assign w_shadowOk = (w_shHTotal <= MAX_TOTAL) && (w_shVTotal <= MAX_TOTAL);

    assign w_wrap        = w_hLast && w_vLast;
    assign w_commit      = w_wrap && ((r_state == ST_PENDING) || cfgApply);
    assign w_writeReject = cfgWe && (cfgData == '0) &&
                           (cfgAddr inside {ADDR_H_RES, ADDR_H_SYNC, ADDR_V_RES, ADDR_V_SYNC});

    always_comb begin
        w_stateNext = r_state;
        if (w_commit) begin
            w_stateNext = ST_IDLE;
        end else if (cfgApply) begin
            w_stateNext = ST_PENDING;
        end
    end

    always_ff @(posedge clkPixel or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A write in the wrap cycle lands after the commit has sampled the shadow.
    always_ff @(posedge clkPixel or negedge nReset) begin
        if (!nReset) begin
            r_shadow <= CFG_DEFAULT;
        end else if (cfgWe && !w_writeReject) begin
            case (cfgAddr)
                ADDR_H_RES:  r_shadow.hRes        <= cfgData;
                ADDR_H_FP:   r_shadow.hFp         <= cfgData;
                ADDR_H_SYNC: r_shadow.hSync       <= cfgData;
                ADDR_H_BP:   r_shadow.hBp         <= cfgData;
                ADDR_V_RES:  r_shadow.vRes        <= cfgData;
                ADDR_V_FP:   r_shadow.vFp         <= cfgData;
                ADDR_V_SYNC: r_shadow.vSync       <= cfgData;
                ADDR_V_BP:   r_shadow.vBp         <= cfgData;
                ADDR_POL:    r_shadow.pol         <= cfgData[1:0];
                ADDR_LINE:   r_shadow.lineCompare <= cfgData;
                ADDR_SCALE: begin
                    r_shadow.hShift <= cfgData[1:0];
                    r_shadow.vShift <= cfgData[3:2];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkPixel or negedge nReset) begin
        if (!nReset) begin
            r_active <= CFG_DEFAULT;
            r_hCount <= '0;
            r_vCount <= '0;
            r_cfgErr <= 1'b0;
        end else begin
            r_cfgErr <= w_writeReject || (w_commit && !w_shadowOk);
            if (w_commit && w_shadowOk) begin
                r_active <= r_shadow;
            end
            if (w_hLast) begin
                r_hCount <= '0;
                r_vCount <= w_vLast ? '0 : r_vCount + CNT_W'(1);
            end else begin
                r_hCount <= r_hCount + CNT_W'(1);
            end
        end
    end

    assign cfgBusy    = (r_state == ST_PENDING);
    assign cfgErr     = r_cfgErr;
    assign h_count    = r_hCount;
    assign v_count    = r_vCount;
    assign x          = w_hCoord;
    assign y          = w_vCoord;
    assign hsync      = w_hsync;
    assign vsync      = w_vsync;
    assign csync      = ~(w_hsync ^ w_vsync);
    assign blank      = ~(w_hActive && w_vActive);
    assign frameDrawn = (r_vCount == '0) && (int'(r_hCount) < INTERRUPT_TICKS);
    assign lineIrq    = (r_hCount == '0) && (r_vCount == r_active.lineCompare);

endmodule

// File: tb/tb_timing_generator_prog.sv
// Randomised bench for the programmable timing generator, checked every cycle
// against a frame-position reference model with shadow/active register arrays.
module tb_timing_generator_prog;

    // Reduced reset timing keeps whole default frames affordable to simulate.
    localparam int         H_RES_D   = 40;
    localparam int         H_FP_D    = 4;
    localparam int         H_SYNC_D  = 6;
    localparam int         H_BP_D    = 5;
    localparam int         V_RES_D   = 30;
    localparam int         V_FP_D    = 2;
    localparam int         V_SYNC_D  = 2;
    localparam int         V_BP_D    = 3;
    localparam logic [1:0] POL_D     = 2'b01;
    localparam int         IRQ_TICKS = 8;
    localparam int         DEF_FRAME = (H_RES_D + H_FP_D + H_SYNC_D + H_BP_D) *
                                       (V_RES_D + V_FP_D + V_SYNC_D + V_BP_D);

    typedef int cfg_arr_t [11];

    logic        clkPixel = 1'b0;
    logic        nReset;
    logic        cfgWe;
    logic [3:0]  cfgAddr;
    logic [11:0] cfgData;
    logic        cfgApply;
    logic        cfgBusy;
    logic        cfgErr;
    logic [11:0] h_count;
    logic [11:0] v_count;
    logic [11:0] x;
    logic [11:0] y;
    logic        hsync;
    logic        vsync;
    logic        csync;
    logic        blank;
    logic        frameDrawn;
    logic        lineIrq;

    int checks = 0;
    int errors = 0;

    cfg_arr_t sh;
    cfg_arr_t act;
    int       pix;
    bit       pend;
    bit       expErr;

    timing_generator_prog #(
        .H_RES_D         (H_RES_D),
        .H_FP_D          (H_FP_D),
        .H_SYNC_D        (H_SYNC_D),
        .H_BP_D          (H_BP_D),
        .V_RES_D         (V_RES_D),
        .V_FP_D          (V_FP_D),
        .V_SYNC_D        (V_SYNC_D),
        .V_BP_D          (V_BP_D),
        .POL_D           (POL_D),
        .INTERRUPT_TICKS (IRQ_TICKS)
    ) dut (
        .clkPixel   (clkPixel),
        .nReset     (nReset),
        .cfgWe      (cfgWe),
        .cfgAddr    (cfgAddr),
        .cfgData    (cfgData),
        .cfgApply   (cfgApply),
        .cfgBusy    (cfgBusy),
        .cfgErr     (cfgErr),
        .h_count    (h_count),
        .v_count    (v_count),
        .x          (x),
        .y          (y),
        .hsync      (hsync),
        .vsync      (vsync),
        .csync      (csync),
        .blank      (blank),
        .frameDrawn (frameDrawn),
        .lineIrq    (lineIrq)
    );

    always #5 clkPixel = ~clkPixel;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Base 0 selects the horizontal fields, base 4 the vertical ones.
    function automatic int totalOf(input cfg_arr_t c, input int base);
        return c[base] + c[base+1] + c[base+2] + c[base+3];
    endfunction

    function automatic int frameLen();
        return totalOf(act, 0) * totalOf(act, 4);
    endfunction

    task automatic modelReset();
        sh[0] = H_RES_D; sh[1] = H_FP_D; sh[2] = H_SYNC_D; sh[3] = H_BP_D;
        sh[4] = V_RES_D; sh[5] = V_FP_D; sh[6] = V_SYNC_D; sh[7] = V_BP_D;
        sh[8] = int'(POL_D); sh[9] = 0; sh[10] = 0;
        act    = sh;
        pix    = 0;
        pend   = 1'b0;
        expErr = 1'b0;
    endtask

    task automatic modelStep(input bit we, input int addr, input int data, input bit apply);
        cfg_arr_t old;
        bit       wrap;
        bit       commit;
        old    = sh;
        wrap   = (pix == frameLen() - 1);
        commit = wrap && (pend || apply);
        expErr = 1'b0;
        if (we) begin
            if ((addr == 0 || addr == 2 || addr == 4 || addr == 6) && data == 0) expErr = 1'b1;
            else if (addr == 8)  sh[8]    = data & 3;
            else if (addr == 10) sh[10]   = data & 15;
            else if (addr <= 9)  sh[addr] = data;
        end
        pix = wrap ? 0 : pix + 1;
        if (commit) begin
            if (totalOf(old, 0) <= 4096 && totalOf(old, 4) <= 4096) act = old;
            else expErr = 1'b1;
            pend = 1'b0;
        end else if (apply) begin
            pend = 1'b1;
        end
    endtask

    task automatic checkAll();
        int ht, h, v, hSta, vSta, ex, ey;
        bit hIn, vIn, hs, vs, hAct, vAct, fd, li;
        ht   = totalOf(act, 0);
        h    = pix % ht;
        v    = pix / ht;
        hSta = act[1] + act[2] + act[3];
        vSta = act[5] + act[6] + act[7];
        hIn  = (h >= act[1]) && (h < act[1] + act[2]);
        vIn  = (v >= act[5]) && (v < act[5] + act[6]);
        hs   = ((act[8] & 1) != 0) ? hIn : !hIn;
        vs   = ((act[8] & 2) != 0) ? vIn : !vIn;
        hAct = (h >= hSta);
        vAct = (v >= vSta);
        ex   = hAct ? ((h - hSta) >> (act[10] & 3)) : 0;
        ey   = vAct ? ((v - vSta) >> ((act[10] >> 2) & 3)) : 0;
        fd   = (v == 0) && (h < IRQ_TICKS);
        li   = (h == 0) && (v == act[9]);
        checkOutput("counters", {h_count, v_count}, {12'(h), 12'(v)});
        checkOutput("coords", {x, y}, {12'(ex), 12'(ey)});
        checkOutput("video", {hsync, vsync, csync, blank}, {hs, vs, !(hs ^ vs), !(hAct && vAct)});
        checkOutput("irq", {frameDrawn, lineIrq}, {fd, li});
        checkOutput("cfg", {cfgBusy, cfgErr}, {pend, expErr});
    endtask

    task automatic applyStimulus(input bit we, input int addr, input int data, input bit apply);
        cfgWe    = we;
        cfgAddr  = 4'(addr);
        cfgData  = 12'(data);
        cfgApply = apply;
        modelStep(we, addr, data, apply);
        @(posedge clkPixel);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 1'b0);
    endtask

    task automatic writeReg(input int addr, input int data);
        applyStimulus(1'b1, addr, data, 1'b0);
    endtask

    task automatic requestApply();
        applyStimulus(1'b0, 0, 0, 1'b1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (cfgBusy && n < budget) begin
            applyStimulus(1'b0, 0, 0, 1'b0);
            n++;
        end
        checkOutput("busyClear", {31'd0, cfgBusy}, 32'd0);
    endtask

    // Counts clocks until the counters return to the origin.
    task automatic measureFrame(input string tag, input int budget, input int expected);
        int n = 0;
        do begin
            applyStimulus(1'b0, 0, 0, 1'b0);
            n++;
        end while (!(h_count == 12'd0 && v_count == 12'd0) && n < budget);
        checkOutput(tag, n, expected);
    endtask

    task automatic countLineIrq(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'b0, 0, 0, 1'b0);
            if (lineIrq) pulses++;
        end
    endtask

    task automatic doReset();
        cfgWe    = 1'b0;
        cfgAddr  = '0;
        cfgData  = '0;
        cfgApply = 1'b0;
        #2;
        nReset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clkPixel);
        #1;
        checkAll();
        @(negedge clkPixel);
        nReset = 1'b1;
    endtask

    task automatic randomWrite();
        int addr, data, r;
        addr = $urandom_range(0, 15);
        r    = $urandom_range(0, 19);
        if (addr <= 7) begin
            if (r == 0)                    data = 0;
            else if (r == 1 && addr == 0)  data = 4095;
            else                           data = $urandom_range(1, 6);
        end else if (addr == 9) begin
            data = $urandom_range(0, 40);
        end else begin
            data = $urandom_range(0, 4095);
        end
        writeReg(addr, data);
    endtask

    initial begin
        int pulses;
        nReset   = 1'b1;
        cfgWe    = 1'b0;
        cfgAddr  = '0;
        cfgData  = '0;
        cfgApply = 1'b0;
        #3;
        doReset();
        idle(300);

        // Tiny mode, requested mid-frame.
        writeReg(0, 4); writeReg(1, 1); writeReg(2, 1); writeReg(3, 1);
        writeReg(4, 2); writeReg(5, 1); writeReg(6, 1); writeReg(7, 1);
        requestApply();
        waitIdle(3000);
        measureFrame("smallFrame", 200, 35);
        idle(40);

        // Horizontal scaling, then a write landing exactly in the wrap cycle.
        writeReg(10, 1); writeReg(0, 8);
        requestApply();
        waitIdle(200);
        idle(60);
        requestApply();
        while (pix != frameLen() - 1) applyStimulus(1'b0, 0, 0, 1'b0);
        writeReg(0, 6);
        idle(60);
        requestApply();
        waitIdle(200);
        idle(60);
        writeReg(0, 8);

        // Rejected zero write and rejected oversized commit.
        writeReg(2, 0);
        idle(5);
        writeReg(3, 200); writeReg(0, 4000);
        requestApply();
        waitIdle(200);
        idle(80);
        writeReg(3, 1); writeReg(0, 8);

        // Raster compare inside and beyond the frame.
        writeReg(4, 110); writeReg(9, 100);
        requestApply();
        waitIdle(2000);
        countLineIrq(2 * frameLen(), pulses);
        checkOutput("lineIrqTwoFrames", pulses, 2);
        writeReg(9, 600);
        requestApply();
        waitIdle(2000);
        countLineIrq(2 * frameLen(), pulses);
        checkOutput("lineIrqNever", pulses, 0);

        // Reset while a commit is pending.
        writeReg(0, 20);
        requestApply();
        idle(5);
        doReset();
        measureFrame("defaultFrame", 5000, DEF_FRAME);

        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < 120; c++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 12)      randomWrite();
                else if (r < 15) requestApply();
                else             applyStimulus(1'b0, 0, 0, 1'b0);
            end
        end
        idle(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timing_generator_prog.md
Name: timing_generator_prog

Overview:
- Second-generation video timing generator for the GPU. It produces the raster counters, sync, blank and interrupt signals.
- All timing fields, sync polarities, pixel scaling and a raster-line compare are programmable at run time through a small register write port.
- New settings are held in shadow registers and take effect atomically at a frame boundary, so mode changes never produce a torn frame.
- It sits between the CPU-side GPU control logic and the pixel pipeline, in the clkPixel domain.

Parameters:
- H_RES_D, 640, reset value of horizontal active pixels
- H_FP_D, 16, reset horizontal front porch
- H_SYNC_D, 96, reset horizontal sync width
- H_BP_D, 48, reset horizontal back porch
- V_RES_D, 480, reset vertical active lines
- V_FP_D, 10, reset vertical front porch
- V_SYNC_D, 2, reset vertical sync width
- V_BP_D, 33, reset vertical back porch
- POL_D, 2'b00, reset polarity {V_POL,H_POL}; 1 = positive
- INTERRUPT_TICKS, 32, frameDrawn high length in pixel clocks

Ports:
- clkPixel  in  1  pixel clock
- nReset  in  1  asynchronous, active-low reset
- cfgWe  in  1  shadow register write strobe
- cfgAddr  in  4  shadow register index
- cfgData  in  12  write data
- cfgApply  in  1  request commit of shadow registers at next frame wrap
- cfgBusy  out  1  commit pending
- cfgErr  out  1  one-cycle pulse: rejected write or rejected commit
- h_count  out  12  line position, 0..H_TOTAL-1
- v_count  out  12  frame position, 0..V_TOTAL-1
- x  out  12  scaled active pixel column, 0 outside active
- y  out  12  scaled active line, 0 outside active
- hsync, vsync, csync, blank  out  1 each  video control
- frameDrawn  out  1  frame interrupt
- lineIrq  out  1  raster compare interrupt pulse

Behaviour:
- Register map (cfgAddr):
  - 0 H_RES, 1 H_FP, 2 H_SYNC, 3 H_BP
  - 4 V_RES, 5 V_FP, 6 V_SYNC, 7 V_BP
  - 8 polarity [1:0]
  - 9 lineCompare
  - 10 scale: [1:0] hShift, [3:2] vShift
  - 11..15 writes ignored silently
- Writes of 0 to addresses 0, 2, 4 or 6 are ignored and pulse cfgErr.
- H_TOTAL = H_FP+H_SYNC+H_BP+H_RES; V_TOTAL likewise. Both are computed with a 14-bit sum.
- Line order is front porch, sync, back porch, active:
  - hsync asserted (per polarity) for h_count in [H_FP, H_FP+H_SYNC-1].
  - Active region is h_count in [HA_STA, H_TOTAL-1], with HA_STA = H_FP+H_SYNC+H_BP.
  - Vertical is identical on v_count.
- blank = 1 unless both h and v are active.
- csync = ~(hsync ^ vsync).
- h_count increments every clock. At H_TOTAL-1 it wraps to 0 and v_count increments; v_count wraps to 0 after V_TOTAL-1.
- x = (h_count-HA_STA) >> hShift and y = (v_count-VA_STA) >> vShift while active; both are 0 otherwise.
- All video outputs are combinational from the registered counters and the active config: zero latency relative to h_count/v_count.
- frameDrawn = (v_count==0 && h_count<INTERRUPT_TICKS).
- lineIrq = (h_count==0 && v_count==lineCompare), one cycle per frame. If lineCompare >= V_TOTAL, lineIrq never fires.
- Commit state machine, IDLE -> PENDING -> IDLE:
  - cfgApply sets PENDING.
  - At the wrap cycle (h_count==H_TOTAL-1 && v_count==V_TOTAL-1) with PENDING or cfgApply asserted, the shadow contents as of before that edge are checked.
  - If H_TOTAL and V_TOTAL are both <= 4096: shadow copies to active, counters go to 0 and run under the new timing, state returns to IDLE.
  - Otherwise: active is unchanged, cfgErr pulses, state returns to IDLE.
  - cfgBusy = PENDING.
- cfgWe during PENDING updates the shadow. The new value is included in the commit unless it is written in the wrap cycle itself; that write lands for the next commit.
- nReset asserted at any time, including mid-frame or while PENDING:
  - h_count and v_count go to 0.
  - Shadow and active registers load the *_D parameters, polarity POL_D, lineCompare 0, scale 0.
  - State goes to IDLE; cfgErr is 0.
  - Outputs follow from these counter/config values: hsync/vsync at inactive level, blank=1, frameDrawn=1, lineIrq=1 on the first cycle.

Decomposition:
- Shared package gpu_timing_pkg holds:
  - register address constants;
  - the timing_cfg_t struct (eight 12-bit fields, 2-bit pol, 12-bit lineCompare, 2+2-bit shifts);
  - the default constant built from the parameters.
- One sub-module, timing_axis, is instantiated twice (horizontal, vertical). It takes a counter and the FP/SYNC/BP/RES/pol/shift inputs and returns sync, active and scaled coordinate.

Test Plan:
- Reset, then run with defaults: hsync low exactly for h 16..111; blank low for h 160..799 when v 45..524; 800 clocks per line; 420000 clocks per frame; frameDrawn high 32 clocks per frame.
- Write H_RES=4, H_FP=1, H_SYNC=1, H_BP=1, V_RES=2, V_FP=1, V_SYNC=1, V_BP=1, then cfgApply mid-frame:
  - cfgBusy stays high until the wrap;
  - then H_TOTAL=7, V_TOTAL=5, frame of 35 clocks, hsync low only at h=1.
- With the small mode above, scale hShift=1 and H_RES=8: x sequence 0,0,1,1,2,2,3,3 over h 3..10.
- Write 0 to address 2 -> cfgErr one pulse, shadow unchanged. Set H_RES=4000 and cfgApply -> cfgErr at wrap, timing unchanged, cfgBusy clears.
- lineCompare=100 -> lineIrq single pulse at h=0, v=100, once per frame. lineCompare=600 -> no pulse.
- Assert nReset mid-line while PENDING -> counters 0, defaults restored, cfgBusy 0, next frame of 420000 clocks.
